mult_stall_controller: RTL
==========================

MULT_STALL_CONTROLLER -- requirements
Module: mult_stall_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 64, operand/result width.
REQ-002 SHALL have parameter LATENCY, default 4, cycles from mul_start to valid mul_result (legal 2..16).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mul_valid_ID_EX  input  1  instruction held in ID/EX is a valid MUL (opcode 0110011, funct7 0000001, funct3 000).
REQ-006 kill  input  1  squash the in-flight MUL (trap/flush from later stage).
REQ-007 op_a, op_b  input  DATA_W each  EX-stage operands after forwarding.
REQ-008 mul_result  input  DATA_W  product from external multiplier.
REQ-009 mul_start  output  1  one-cycle start pulse to multiplier.
REQ-010 mul_a, mul_b  output  DATA_W each  registered operands to multiplier.
REQ-011 PCWrite, Write_IF_ID, Write_ID_EX  output  1 each  pipeline-register write enables (1 = advance).
REQ-012 bubble_EX_MEM  output  1  1 = insert NOP into EX/MEM.
REQ-013 result, result_valid  output  DATA_W, 1  captured product and its qualifier.
REQ-014 busy  output  1  high in BUSY state.
REQ-015 mul_count  output  16  saturating count of completed MULs.

Function
REQ-016 FSM states SHALL be IDLE, BUSY, DONE.
REQ-017 IDLE with mul_valid_ID_EX=1 and kill=0: latch op_a/op_b into mul_a/mul_b, assert mul_start (combinational, this cycle only), load counter with LATENCY-1, go BUSY.
REQ-018 BUSY: decrement counter each cycle; when counter==0, capture mul_result into result, go DONE.
REQ-019 DONE: result_valid=1 for exactly one cycle, increment mul_count (hold at 0xFFFF), go IDLE unconditionally.
REQ-020 Stall: PCWrite=Write_IF_ID=Write_ID_EX=0 and bubble_EX_MEM=1 in IDLE-with-start-condition and in all BUSY cycles; otherwise 1,1,1,0.
REQ-021 MUL entering EX at cycle T SHALL release the stall in cycle T+LATENCY+1 (DONE); stall length = LATENCY+1 cycles.
REQ-022 DONE SHALL not re-trigger on the same MUL; a back-to-back MUL entering ID/EX after DONE starts in the next IDLE cycle.
REQ-023 kill in BUSY: go IDLE next cycle, no capture, no result_valid, no count increment; stall released in the kill cycle.
REQ-024 kill in IDLE with mul_valid_ID_EX=1: kill wins; no mul_start, no stall.
REQ-025 kill in DONE: ignored; completion stands.
REQ-026 result SHALL hold its last captured value until the next capture; mul_a/mul_b hold between starts.
REQ-027 Top level ANDs these write enables with the load-use hazard unit's; this block holds no load-use logic.

Reset
REQ-028 rst=1: state IDLE, counter 0, mul_a/mul_b/result 0, mul_count 0.
REQ-029 Output values during/after reset: mul_start 0, result_valid 0, busy 0; PCWrite/Write_IF_ID/Write_ID_EX 1, bubble_EX_MEM 0 unless mul_valid_ID_EX=1 in IDLE.
REQ-030 rst mid-BUSY SHALL abandon the operation with no result_valid.

Structure
REQ-031 Shared package SHALL hold state encoding (2-bit: IDLE=00, BUSY=01, DONE=10), MUL opcode/funct7/funct3 constants.
REQ-032 No sub-module required; the multiplier is external. Bench uses a LATENCY-deep behavioural model named mult_pipe_model.

Verification (LATENCY=4)
REQ-033 Single MUL 7x6 entering EX at cycle 10 -> mul_start cycle 10; stall cycles 10..14; result=42, result_valid cycle 15; mul_count=1.
REQ-034 Back-to-back MULs (3x5 then 0xFFFF_FFFF_FFFF_FFFF x 2) -> two start pulses 6 cycles apart; results 15 then 0xFFFF_FFFF_FFFF_FFFE (low DATA_W bits).
REQ-035 kill at second BUSY cycle -> IDLE next cycle; no result_valid; mul_count unchanged; PCWrite=1 in kill cycle.
REQ-036 kill and mul_valid_ID_EX together in IDLE -> mul_start=0, PCWrite=1, bubble_EX_MEM=0.
REQ-037 rst during BUSY then 2 idle cycles -> state IDLE, result=0, no result_valid, mul_count=0.
REQ-038 mul_count preset via 65535 completions -> 65536th completion leaves mul_count=0xFFFF.

Source files
------------

// File: rtl/mult_stall_controller_pkg.sv
// Shared definitions for the multi-cycle MUL stall controller: FSM state
// encoding, RV64M MUL decode constants and the saturating completion counter.
package mult_stall_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [6:0] MUL_OPCODE = 7'b0110011;
    localparam logic [6:0] MUL_FUNCT7 = 7'b0000001;
    localparam logic [2:0] MUL_FUNCT3 = 3'b000;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == COUNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/mult_stall_controller.sv
// Stalls the pipeline while an external fixed-latency multiplier works on the
// MUL held in ID/EX, then presents the captured product for one cycle.
module mult_stall_controller
    import mult_stall_controller_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mul_valid_ID_EX,
    input  logic              kill,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] mul_result,
    output logic              mul_start,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    output logic              PCWrite,
    output logic              Write_IF_ID,
    output logic              Write_ID_EX,
    output logic              bubble_EX_MEM,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              busy,
    output logic [15:0]       mul_count
);

    localparam int CNT_W = $clog2(LATENCY);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             start_cond;
    logic             stall;

    // A kill in BUSY releases the stall in the same cycle so the flush can proceed.
    always_comb begin
        start_cond    = (state == IDLE) && mul_valid_ID_EX && !kill;
        mul_start     = start_cond && !rst;
        stall         = start_cond || ((state == BUSY) && !kill && !rst);
        PCWrite       = !stall;
        Write_IF_ID   = !stall;
        Write_ID_EX   = !stall;
        bubble_EX_MEM = stall;
        busy          = (state == BUSY) && !rst;
        result_valid  = (state == DONE) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            result    <= '0;
            mul_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_cond) begin
                        mul_a <= op_a;
                        mul_b <= op_b;
                        count <= CNT_W'(LATENCY - 1);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (kill) begin
                        count <= '0;
                        state <= IDLE;
                    end else if (count == '0) begin
                        result <= mul_result;
                        state  <= DONE;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                DONE: begin
                    // The MUL still sitting in ID/EX advances this cycle, so
                    // returning to IDLE cannot restart it.
                    mul_count <= sat_inc16(mul_count);
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
